// File: rtl/baud_gen_frac_pkg.sv
// rtl/baud_gen_frac_pkg.sv - shared constants and divisor helpers for the fractional baud generator
//
// Package baud_pkg:
//   DEF_*        default build constants, used as parameter defaults in the
//                interface and the top level
//   DIV_MIN      smallest integer divisor the generator accepts on a load
//   baud_div_n   N = (clk_hz * 2^frac_w) / (baud * os), truncated
//   baud_int_of  integer part of N (N div 2^frac_w)
//   baud_frac_of fractional part of N (N mod 2^frac_w)
package baud_pkg;

    localparam int DEF_CLK_HZ     = 50000000;
    localparam int DEF_BAUD       = 115200;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DIV_W      = 16;
    localparam int DEF_FRAC_W     = 4;

    // A period of one cycle would make cnt == P-1 true at cnt == 0 and
    // break the first-tick timing, so loads below this are raised to it.
    localparam int DIV_MIN = 2;

    // 64-bit arithmetic: CLK_HZ * 2^FRAC_W overflows 32 bits for fast
    // clocks with wide fractions.
    function automatic longint baud_div_n(
        input longint clk_hz,
        input longint baud,
        input longint os,
        input longint frac_w
    );
        longint scale;
        scale = longint'(1) << frac_w;
        return (clk_hz * scale) / (baud * os);
    endfunction

    function automatic longint baud_int_of(input longint n, input longint frac_w);
        return n >> frac_w;
    endfunction

    function automatic longint baud_frac_of(input longint n, input longint frac_w);
        longint scale;
        scale = longint'(1) << frac_w;
        return n % scale;
    endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// rtl/baud_gen_frac_if.sv - control/tick bundle between the UART and the baud generator
//
// Signals:
//   en          generator enable
//   div_int     integer CLK cycles per rx tick
//   div_frac    fractional CLK cycles per rx tick (units of 1/2^FRAC_W)
//   div_load    one-cycle strobe capturing div_int/div_frac
//   div_pending loaded divisor not yet applied
//   rxclk_en    one-cycle rx oversample tick
//   txclk_en    one-cycle tx bit tick
//   rx_resync   start-bit realignment pulse (only when BAUD_RESYNC_EN is defined)
// Modports: master = UART side driving controls, slave = the generator.
interface baud_gen_frac_if
    import baud_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int FRAC_W = DEF_FRAC_W
);

    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              div_pending;
    logic              rxclk_en;
    logic              txclk_en;
`ifdef BAUD_RESYNC_EN
    logic              rx_resync;

    modport master (
        output en, div_int, div_frac, div_load, rx_resync,
        input  div_pending, rxclk_en, txclk_en
    );

    modport slave (
        input  en, div_int, div_frac, div_load, rx_resync,
        output div_pending, rxclk_en, txclk_en
    );
`else
    modport master (
        output en, div_int, div_frac, div_load,
        input  div_pending, rxclk_en, txclk_en
    );

    modport slave (
        input  en, div_int, div_frac, div_load,
        output div_pending, rxclk_en, txclk_en
    );
`endif

endinterface

// File: rtl/baud_gen_frac_tick_div.sv
// rtl/baud_gen_frac_tick_div.sv - integer+fraction cycle counter producing the rx oversample tick
//
// Module frac_tick_div
//   CLK, RST   clock, synchronous active-high reset
//   en         count enable; low holds cnt/frac_acc at zero
//   clr        realignment: zero cnt/frac_acc and suppress the tick this edge
//   div_int    active integer divisor (>= 2)
//   div_frac   active fractional divisor
//   hit        combinational: this edge completes a period (apply point
//              for the parent's divisor shadow and oversample counter)
//   tick       registered one-cycle tick, high the cycle after a hit edge
import baud_pkg::*;

module frac_tick_div #(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              clr,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              hit,
    output logic              tick
);

    // One extra bit so div_int = 2^DIV_W-1 plus a carry still fits.
    logic [DIV_W:0]    cnt;
    logic [FRAC_W-1:0] frac_acc;
    logic [FRAC_W:0]   frac_sum;
    logic              carry;
    logic [DIV_W:0]    period;

    // The carry out of the fractional accumulator stretches this period
    // by one cycle; over 2^FRAC_W periods that adds exactly div_frac cycles.
    always_comb begin
        frac_sum = {1'b0, frac_acc} + {1'b0, div_frac};
        carry    = frac_sum[FRAC_W];
        period   = {1'b0, div_int} + {{DIV_W{1'b0}}, carry};
        hit      = en && !clr && (cnt == period - {{DIV_W{1'b0}}, 1'b1});
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= '0;
            frac_acc <= '0;
            tick     <= 1'b0;
        end else if (!en || clr) begin
            cnt      <= '0;
            frac_acc <= '0;
            tick     <= 1'b0;
        end else if (hit) begin
            cnt      <= '0;
            frac_acc <= frac_sum[FRAC_W-1:0];
            tick     <= 1'b1;
        end else begin
            cnt      <= cnt + {{DIV_W{1'b0}}, 1'b1};
            tick     <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - run-time programmable fractional baud-rate generator (rx oversample + tx bit ticks)
//
// Ports:
//   CLK   system clock
//   RST   synchronous active-high reset
//   bif   baud_gen_frac_if.slave: en, div_int, div_frac, div_load in;
//         div_pending, rxclk_en, txclk_en out
// Optional feature macro: BAUD_RESYNC_EN adds bif.rx_resync, which
// realigns the oversample phase to a detected start-bit edge.
// The divisor reloads through a shadow register applied only on a tick
// edge (or immediately while disabled), so a period in progress always
// finishes with the divisor it started with.
import baud_pkg::*;

module baud_gen_frac #(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int BAUD_DEFAULT = DEF_BAUD,
    parameter int OVERSAMPLE   = DEF_OVERSAMPLE,
    parameter int DIV_W        = DEF_DIV_W,
    parameter int FRAC_W       = DEF_FRAC_W
) (
    input  logic          CLK,
    input  logic          RST,
    baud_gen_frac_if.slave bif
);

    localparam longint            RST_N    = baud_div_n(CLK_HZ, BAUD_DEFAULT, OVERSAMPLE, FRAC_W);
    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(baud_int_of(RST_N, FRAC_W));
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(baud_frac_of(RST_N, FRAC_W));
    localparam logic [DIV_W-1:0]  MIN_INT  = DIV_W'(DIV_MIN);
    localparam int                OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0]  div_int_act;
    logic [FRAC_W-1:0] div_frac_act;
    logic [DIV_W-1:0]  shadow_int;
    logic [FRAC_W-1:0] shadow_frac;
    logic              pending;
    logic [DIV_W-1:0]  load_int;
    logic              tick_hit;
    logic              rx_tick;
    logic              apply;
    logic              resync;
    logic [OS_W-1:0]   os_cnt;
    logic              tx_q;

`ifdef BAUD_RESYNC_EN
    assign resync = bif.rx_resync;
`else
    assign resync = 1'b0;
`endif

    assign load_int = (bif.div_int < MIN_INT) ? MIN_INT : bif.div_int;

    // While disabled the counter sits at zero, so any edge is a safe
    // point to switch divisors. A resync edge is not a tick, so a pending
    // divisor keeps waiting for the next real one.
    assign apply = tick_hit || !bif.en;

    frac_tick_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_tick_div (
        .CLK      (CLK),
        .RST      (RST),
        .en       (bif.en),
        .clr      (resync),
        .div_int  (div_int_act),
        .div_frac (div_frac_act),
        .hit      (tick_hit),
        .tick     (rx_tick)
    );

    // Shadow/active divisor. A load coinciding with an apply edge lands
    // in the shadow after the old shadow has moved to active, so pending
    // stays set for the newer value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_int_act  <= RST_INT;
            div_frac_act <= RST_FRAC;
            shadow_int   <= '0;
            shadow_frac  <= '0;
            pending      <= 1'b0;
        end else begin
            if (apply && pending) begin
                div_int_act  <= shadow_int;
                div_frac_act <= shadow_frac;
            end
            if (bif.div_load) begin
                shadow_int  <= load_int;
                shadow_frac <= bif.div_frac;
                pending     <= 1'b1;
            end else if (apply) begin
                pending     <= 1'b0;
            end
        end
    end

    // Bit tick: every OVERSAMPLE-th rx tick, registered alongside it.
    always_ff @(posedge CLK) begin
        if (RST || !bif.en || resync) begin
            os_cnt <= '0;
            tx_q   <= 1'b0;
        end else if (tick_hit) begin
            tx_q   <= (os_cnt == OS_LAST);
            os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + {{(OS_W-1){1'b0}}, 1'b1};
        end else begin
            tx_q   <= 1'b0;
        end
    end

    assign bif.rxclk_en    = rx_tick;
    assign bif.txclk_en    = tx_q;
    assign bif.div_pending = pending;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - self-checking bench for baud_gen_frac
module tb_baud_gen_frac;

    logic CLK;
    logic RST;

    int n_checks;
    int n_fail;

    baud_gen_frac_if #(.DIV_W(16), .FRAC_W(4)) bif ();

    baud_gen_frac #(
        .CLK_HZ       (50000000),
        .BAUD_DEFAULT (115200),
        .OVERSAMPLE   (16),
        .DIV_W        (16),
        .FRAC_W       (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bif (bif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] d_int;
        logic [3:0]  d_frac;
        logic [63:0] per;   // eight expected periods, first in the top byte
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; counts rising edges until rxclk_en is seen.
    task automatic wait_rx(input int budget, output int cycles, output logic tx_seen);
        logic found;
        found   = 1'b0;
        cycles  = 0;
        tx_seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            cycles++;
            if (bif.rxclk_en) begin
                tx_seen = bif.txclk_en;
                found   = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_timeout: no rxclk_en within %0d cycles, required one", budget);
        end
    endtask

    task automatic wait_tx(input int budget, output int cycles);
        logic found;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            cycles++;
            if (bif.txclk_en) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_timeout: no txclk_en within %0d cycles, required one", budget);
        end
    endtask

    task automatic load_div(input int d_int, input int d_frac);
        bif.div_int  = 16'(d_int);
        bif.div_frac = 4'(d_frac);
        bif.div_load = 1'b1;
        @(negedge CLK);
        bif.div_load = 1'b0;
    endtask

    initial begin
        int   c;
        int   sum;
        int   tx_idx;
        int   bad;
        logic tx;
        logic [63:0] pv;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{16'd27, 4'd2,  {8'd27, 8'd27, 8'd27, 8'd27, 8'd27, 8'd27, 8'd27, 8'd28}};
        vecs[1] = '{16'd4,  4'd0,  {8'd4,  8'd4,  8'd4,  8'd4,  8'd4,  8'd4,  8'd4,  8'd4}};
        vecs[2] = '{16'd0,  4'd8,  {8'd2,  8'd3,  8'd2,  8'd3,  8'd2,  8'd3,  8'd2,  8'd3}};
        vecs[3] = '{16'd5,  4'd15, {8'd5,  8'd6,  8'd6,  8'd6,  8'd6,  8'd6,  8'd6,  8'd6}};
        vecs[4] = '{16'd1,  4'd0,  {8'd2,  8'd2,  8'd2,  8'd2,  8'd2,  8'd2,  8'd2,  8'd2}};
        vecs[5] = '{16'd3,  4'd4,  {8'd3,  8'd3,  8'd3,  8'd4,  8'd3,  8'd3,  8'd3,  8'd4}};
        vecs[6] = '{16'd10, 4'd12, {8'd10, 8'd11, 8'd11, 8'd11, 8'd10, 8'd11, 8'd11, 8'd11}};

        RST          = 1'b1;
        bif.en       = 1'b0;
        bif.div_int  = '0;
        bif.div_frac = '0;
        bif.div_load = 1'b0;
`ifdef BAUD_RESYNC_EN
        bif.rx_resync = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset_rxclk_en", int'(bif.rxclk_en), 0);
        check("reset_txclk_en", int'(bif.txclk_en), 0);
        check("reset_div_pending", int'(bif.div_pending), 0);

        // Default divisor 27 + 2/16: 16 rx ticks in 434 cycles, tx on the 16th
        RST    = 1'b0;
        bif.en = 1'b1;
        sum    = 0;
        tx_idx = 0;
        for (int i = 1; i <= 16; i++) begin
            wait_rx(200, c, tx);
            sum += c;
            if (tx && tx_idx == 0) tx_idx = i;
        end
        check("default_16_ticks_cycles", sum, 434);
        check("default_first_tx_tick_index", tx_idx, 16);
        wait_tx(1000, c);
        check("default_tx_interval", c, 434);

        // Mid-period load of 4/0: current period finishes at 27
        repeat (5) @(negedge CLK);
        load_div(4, 0);
        check("midload_pending_set", int'(bif.div_pending), 1);
        wait_rx(200, c, tx);
        check("midload_old_period", 6 + c, 27);
        check("midload_pending_clear", int'(bif.div_pending), 0);
        for (int i = 0; i < 3; i++) begin
            wait_rx(200, c, tx);
            check("midload_new_period", c, 4);
        end
        wait_tx(1000, c);
        wait_tx(1000, c);
        check("midload_tx_interval", c, 64);

        // Enable dropped for 10 cycles mid-period
        @(negedge CLK);
        @(negedge CLK);
        bif.en = 1'b0;
        bad    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bif.rxclk_en || bif.txclk_en) bad++;
        end
        check("en_low_ticks", bad, 0);
        bif.en = 1'b1;
        tx_idx = 0;
        for (int i = 1; i <= 16; i++) begin
            wait_rx(200, c, tx);
            if (i == 1) check("reenable_first_period", c, 4);
            if (tx && tx_idx == 0) tx_idx = i;
        end
        check("reenable_tx_tick_index", tx_idx, 16);

        // Divisor table, each loaded while disabled
        for (int v = 0; v < 7; v++) begin
            bif.en       = 1'b0;
            bif.div_load = 1'b0;
            @(negedge CLK);
            load_div(int'(vecs[v].d_int), int'(vecs[v].d_frac));
            check("table_pending_after_load", int'(bif.div_pending), 1);
            @(negedge CLK);
            check("table_pending_after_apply", int'(bif.div_pending), 0);
            bif.en = 1'b1;
            pv = vecs[v].per;
            for (int k = 0; k < 8; k++) begin
                wait_rx(200, c, tx);
                check($sformatf("table_v%0d_period%0d", v, k), c, int'(pv[(7-k)*8 +: 8]));
            end
        end

        // Reset while a load is pending
        load_div(9, 0);
        check("rst_pending_before", int'(bif.div_pending), 1);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_pending_cleared", int'(bif.div_pending), 0);
        check("rst_rxclk_en", int'(bif.rxclk_en), 0);
        check("rst_txclk_en", int'(bif.txclk_en), 0);
        RST = 1'b0;
        wait_rx(200, c, tx);
        check("rst_default_period1", c, 27);
        wait_rx(200, c, tx);
        check("rst_default_period2", c, 27);
        check("rst_pending_after", int'(bif.div_pending), 0);

        // Two loads while pending: last one wins
        load_div(5, 0);
        load_div(3, 0);
        wait_rx(200, c, tx);
        check("lastwins_old_period", 2 + c, 27);
        check("lastwins_pending_clear", int'(bif.div_pending), 0);
        wait_rx(200, c, tx);
        check("lastwins_new_period", c, 3);

        // Load on the apply edge: shadow takes the new value, stays pending
        load_div(6, 0);
        @(negedge CLK);
        load_div(7, 0);
        check("apply_edge_rx_tick", int'(bif.rxclk_en), 1);
        check("apply_edge_pending_kept", int'(bif.div_pending), 1);
        wait_rx(200, c, tx);
        check("apply_edge_first_period", c, 6);
        check("apply_edge_pending_clear", int'(bif.div_pending), 0);
        wait_rx(200, c, tx);
        check("apply_edge_second_period", c, 7);

`ifdef BAUD_RESYNC_EN
        // Resync 5 cycles after a tick with divisor 8
        bif.en = 1'b0;
        @(negedge CLK);
        load_div(8, 0);
        @(negedge CLK);
        bif.en = 1'b1;
        wait_rx(200, c, tx);
        check("resync_pre_period", c, 8);
        repeat (4) @(negedge CLK);
        bif.rx_resync = 1'b1;
        @(negedge CLK);
        bif.rx_resync = 1'b0;
        check("resync_edge_no_tick", int'(bif.rxclk_en), 0);
        wait_rx(200, c, tx);
        check("resync_next_tick", c, 8);
        tx_idx = tx ? 1 : 0;
        for (int i = 2; i <= 16; i++) begin
            wait_rx(200, c, tx);
            if (tx && tx_idx == 0) tx_idx = i;
        end
        check("resync_tx_tick_index", tx_idx, 16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
